// File: rtl/flags_ctx_pkg.sv
// Shared constants for the flags context: flag bit positions, opcode match
// patterns and the write-mask constants used by the mask decoder.
package flags_ctx_pkg;

  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_S = 3;

  localparam int PHASE_H     = 3;
  localparam int PHASE_M_DEF = 2;

  localparam int OPC_W = 13;

  // An opcode matches when (opc & care) == val; clear care bits are don't-care.
  typedef struct packed {
    logic [OPC_W-1:0] val;
    logic [OPC_W-1:0] care;
  } opc_pat_t;

  localparam opc_pat_t zADD = '{val: {8'h01, 2'b00, 3'b000}, care: {8'hFF, 2'b00, 3'b000}};
  localparam opc_pat_t zSUB = '{val: {8'h02, 2'b00, 3'b000}, care: {8'hFF, 2'b00, 3'b000}};
  localparam opc_pat_t zCMP = '{val: {8'h03, 2'b00, 3'b000}, care: {8'hFF, 2'b00, 3'b000}};
  localparam opc_pat_t zSLL = '{val: {8'h08, 2'b01, 3'b000}, care: {8'hFF, 2'b11, 3'b000}};
  localparam opc_pat_t zAND = '{val: {8'h10, 2'b00, 3'b000}, care: {8'hFF, 2'b00, 3'b000}};
  localparam opc_pat_t zOR  = '{val: {8'h11, 2'b00, 3'b000}, care: {8'hFF, 2'b00, 3'b000}};
  localparam opc_pat_t zXOR = '{val: {8'h12, 2'b00, 3'b000}, care: {8'hFF, 2'b00, 3'b000}};

  localparam logic [3:0] WM_ALL = 4'b1111;
  localparam logic [3:0] WM_ZS  = 4'b1100;

  function automatic logic opc_match(input logic [OPC_W-1:0] opc, input opc_pat_t pat);
    return (opc & pat.care) == pat.val;
  endfunction

endpackage

// File: rtl/flags_wmask_dec.sv
// Combinational opcode-to-flag-write-mask decoder; also usable by hazard logic.
module flags_wmask_dec
  import flags_ctx_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic [7:0]        op1,
  input  logic [1:0]        op2,
  input  logic [2:0]        op3,
  output logic [FLAG_W-1:0] wmask
);

  localparam logic [FLAG_W-1:0] M_ALL = {FLAG_W{1'b1}};
  localparam logic [FLAG_W-1:0] M_ZS  = FLAG_W'(WM_ZS);

  logic [OPC_W-1:0] opc;
  assign opc = {op1, op2, op3};

  always_comb begin
    wmask = '0;
    if (opc_match(opc, zADD) || opc_match(opc, zSUB) ||
        opc_match(opc, zCMP) || opc_match(opc, zSLL)) begin
      wmask = M_ALL;
    end else if (opc_match(opc, zAND) || opc_match(opc, zOR) || opc_match(opc, zXOR)) begin
      wmask = M_ZS;
    end
  end

endmodule

// File: rtl/flags_ctx.sv
// Condition flags register with masked phase-m update, direct load and a
// LIFO save/restore stack for interrupt entry and return.
module flags_ctx
  import flags_ctx_pkg::*;
#(
  parameter int FLAG_W  = 4,
  parameter int DEPTH   = 4,
  parameter int PHASE_W = PHASE_H + 1,
  parameter int PHASE_M = PHASE_M_DEF,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase,
  input  logic [7:0]         op1,
  input  logic [1:0]         op2,
  input  logic [2:0]         op3,
  input  logic [FLAG_W-1:0]  flags_in,
  input  logic               wr_en,
  input  logic [FLAG_W-1:0]  wr_data,
  input  logic               push,
  input  logic               pop,
  input  logic               err_clr,
  output logic [FLAG_W-1:0]  flags_out,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               err_ovf,
  output logic               err_unf
);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;
  logic [FLAG_W-1:0] stack_q [DEPTH];
  logic [FLAG_W-1:0] stack_d [DEPTH];

  logic [FLAG_W-1:0] wmask;
  logic [FLAG_W-1:0] top_flags;
  logic              full_w, empty_w;
  logic              push_ok, pop_ok, ovf_evt, unf_evt;
  logic              unused_phase;

  assign unused_phase = ^phase;

  flags_wmask_dec #(.FLAG_W(FLAG_W)) u_dec (
    .op1   (op1),
    .op2   (op2),
    .op3   (op3),
    .wmask (wmask)
  );

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // Simultaneous push and pop cancel each other without raising an error.
  assign push_ok = push & ~pop & ~full_w;
  assign pop_ok  = pop & ~push & ~empty_w;
  assign ovf_evt = push & ~pop & full_w;
  assign unf_evt = pop & ~push & empty_w;

  always_comb begin
    top_flags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CNT_W'(i + 1)) top_flags = stack_q[i];
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = top_flags;
    end else if (wr_en) begin
      flags_d = wr_data;
    end else if (phase[PHASE_M]) begin
      flags_d = (flags_q & ~wmask) | (flags_in & wmask);
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_ok)     count_d = count_q + CNT_W'(1);
    else if (pop_ok) count_d = count_q - CNT_W'(1);
  end

  // The saved value is the flags before this cycle's update.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (push_ok && count_q == CNT_W'(i)) stack_d[i] = flags_q;
    end
  end

  // Setting takes precedence over a same-cycle clear.
  always_comb begin
    err_ovf_d = ovf_evt | (err_ovf_q & ~err_clr);
    err_unf_d = unf_evt | (err_unf_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q   <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      flags_q   <= flags_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign flags_out = flags_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_flags_ctx.sv
// Directed plus randomized check of flags_ctx against a queue-based model.
module tb_flags_ctx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       phase = 4'b0001;
  logic [7:0]       op1 = '0;
  logic [1:0]       op2 = '0;
  logic [2:0]       op3 = '0;
  logic [3:0]       flags_in = '0;
  logic             wr_en = 1'b0;
  logic [3:0]       wr_data = '0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             err_clr = 1'b0;
  logic [3:0]       flags_out;
  logic [CNT_W-1:0] count;
  logic             full, empty, err_ovf, err_unf;

  flags_ctx #(.FLAG_W(4), .DEPTH(DEPTH), .PHASE_W(4), .PHASE_M(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .phase(phase), .op1(op1), .op2(op2), .op3(op3),
    .flags_in(flags_in), .wr_en(wr_en), .wr_data(wr_data), .push(push), .pop(pop),
    .err_clr(err_clr), .flags_out(flags_out), .count(count), .full(full),
    .empty(empty), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_CMP = 8'h03, OP_SLL = 8'h08;
  localparam logic [7:0] OP_AND = 8'h10, OP_OR = 8'h11, OP_XOR = 8'h12, OP_NOP = 8'h40;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] m_flags = '0;
  logic [3:0] m_stk[$];
  bit         m_ovf = 0;
  bit         m_unf = 0;

  function automatic logic [3:0] ref_mask(input logic [7:0] o1, input logic [1:0] o2);
    if (o1 == OP_ADD || o1 == OP_SUB || o1 == OP_CMP) return 4'b1111;
    if (o1 == OP_SLL && o2 == 2'b01) return 4'b1111;
    if (o1 == OP_AND || o1 == OP_OR || o1 == OP_XOR) return 4'b1100;
    return 4'b0000;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".flags"}, 8'(flags_out), 8'(m_flags));
    check({ctx, ".count"}, 8'(count), 8'(m_stk.size()));
    check({ctx, ".full"},  8'(full),  8'(m_stk.size() == DEPTH));
    check({ctx, ".empty"}, 8'(empty), 8'(m_stk.size() == 0));
    check({ctx, ".ovf"},   8'(err_ovf), 8'(m_ovf));
    check({ctx, ".unf"},   8'(err_unf), 8'(m_unf));
    $display("%s: flags=%b count=%0d full=%b empty=%b ovf=%b unf=%b",
             ctx, flags_out, count, full, empty, err_ovf, err_unf);
  endtask

  task automatic step(input string ctx, input bit ph, input logic [7:0] o1, input logic [1:0] o2,
                      input logic [3:0] fin, input bit wen, input logic [3:0] wd,
                      input bit ps, input bit pp, input bit clr);
    logic [3:0] nxt;
    logic [3:0] msk;
    phase = ph ? 4'b0100 : 4'b0001;
    op1 = o1; op2 = o2; op3 = 3'($urandom_range(0, 7));
    flags_in = fin; wr_en = wen; wr_data = wd; push = ps; pop = pp; err_clr = clr;
    @(posedge clk);
    msk = ref_mask(o1, o2);
    nxt = m_flags;
    if (ph) nxt = (m_flags & ~msk) | (fin & msk);
    if (wen) nxt = wd;
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (pp && !ps) begin
      if (m_stk.size() > 0) nxt = m_stk.pop_back();
      else m_unf = 1;
    end
    if (ps && !pp) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_flags);
      else m_ovf = 1;
    end
    m_flags = nxt;
    #1;
    check_all(ctx);
  endtask

  task automatic idle_inputs();
    phase = 4'b0001; wr_en = 0; push = 0; pop = 0; err_clr = 0;
  endtask

  initial begin
    #1;
    check_all("reset");
    @(negedge clk); rst = 1'b1;

    // Phase gating, then full-mask ADD
    step("add_nophase", 0, OP_ADD, 2'b00, 4'b1011, 0, 4'h0, 0, 0, 0);
    step("add_phase",   1, OP_ADD, 2'b00, 4'b1011, 0, 4'h0, 0, 0, 0);

    // Logical ops touch only Z and S; unlisted opcode holds
    step("load_0011", 0, OP_NOP, 2'b00, 4'h0, 1, 4'b0011, 0, 0, 0);
    step("and_zs",    1, OP_AND, 2'b00, 4'b1100, 0, 4'h0, 0, 0, 0);
    step("nop_hold",  1, OP_NOP, 2'b00, 4'b0000, 0, 4'h0, 0, 0, 0);
    step("sll_bad",   1, OP_SLL, 2'b10, 4'b0000, 0, 4'h0, 0, 0, 0);
    step("sll_ok",    1, OP_SLL, 2'b01, 4'b0110, 0, 4'h0, 0, 0, 0);

    // Push saves the pre-update value while CMP updates
    step("load_0101", 0, OP_NOP, 2'b00, 4'h0, 1, 4'b0101, 0, 0, 0);
    step("push_cmp",  1, OP_CMP, 2'b00, 4'b1010, 0, 4'h0, 1, 0, 0);
    step("pop_back",  0, OP_NOP, 2'b00, 4'h0, 0, 4'h0, 0, 1, 0);

    // Fill, overflow, LIFO drain, underflow, clear
    step("load_1", 0, OP_NOP, 2'b00, 4'h0, 1, 4'h1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      step("fill", 0, OP_NOP, 2'b00, 4'h0, 1, 4'(i + 2), 1, 0, 0);
    step("push_full", 1, OP_XOR, 2'b00, 4'b1111, 0, 4'h0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      step("drain", 0, OP_NOP, 2'b00, 4'h0, 0, 4'h0, 0, 1, 0);
    step("pop_empty", 1, OP_ADD, 2'b00, 4'b0110, 0, 4'h0, 0, 1, 0);
    step("err_clr",   0, OP_NOP, 2'b00, 4'h0, 0, 4'h0, 0, 0, 1);
    step("clr_vs_set", 0, OP_NOP, 2'b00, 4'h0, 0, 4'h0, 0, 1, 1);
    step("err_clr2",  0, OP_NOP, 2'b00, 4'h0, 0, 4'h0, 0, 0, 1);

    // Priority: pop beats wr_en and phase update; push+pop cancels
    step("load_9",  0, OP_NOP, 2'b00, 4'h0, 1, 4'h9, 0, 0, 0);
    step("push_9",  0, OP_NOP, 2'b00, 4'h0, 1, 4'h6, 1, 0, 0);
    step("pop_prio", 1, OP_SUB, 2'b00, 4'h3, 1, 4'b1111, 0, 1, 0);
    step("push_pop_wr", 1, OP_SUB, 2'b00, 4'h3, 1, 4'b1111, 1, 1, 0);

    // Build count=3 with err_ovf set, then reset asynchronously mid-cycle
    while (m_stk.size() < DEPTH)
      step("build", 0, OP_NOP, 2'b00, 4'h0, 1, 4'($urandom_range(0, 15)), 1, 0, 0);
    step("build_ovf", 0, OP_NOP, 2'b00, 4'h0, 0, 4'h0, 1, 0, 0);
    step("build_pop", 0, OP_NOP, 2'b00, 4'h0, 0, 4'h0, 0, 1, 0);
    idle_inputs();
    #1 rst = 1'b0;
    #1;
    m_flags = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    check_all("async_rst");
    @(negedge clk); rst = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] o1;
      case ($urandom_range(0, 8))
        0: o1 = OP_ADD; 1: o1 = OP_SUB; 2: o1 = OP_CMP; 3: o1 = OP_SLL;
        4: o1 = OP_AND; 5: o1 = OP_OR;  6: o1 = OP_XOR;
        default: o1 = 8'($urandom_range(0, 255));
      endcase
      step("rand", 1'($urandom_range(0, 1)), o1, 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), $urandom_range(0, 99) < 15, 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
